sram_controller: RTL

//   Memory-side responder for the cache controller's SRAM request interface.
//   - Accepts single-word writes and 64-bit block reads.
//   - Drives the external 16-bit asynchronous SRAM chip with a fixed multi-cycle access window per halfword.
//   - Reports completion with a one-cycle ready pulse.
//   - Sits between the cache controller and the board SRAM pins, below the MEM stage.

---
 rtl/sram_controller_pkg.sv | 29 ++
 rtl/sram_access_timer.sv | 46 ++++
 rtl/sram_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared widths, state encodings and address helper for the SRAM controller slice.
// Imported by the controller top and its access timer.
package sram_controller_pkg;

    localparam int ADDRESS_LEN          = 32;
    localparam int SRAM_DATA_LEN        = 32;
    localparam int CACHE_BLOCK_DATA_LEN = 64;
    localparam int SRAM_BUS_LEN         = 16;
    localparam int SRAM_ADDR_LEN        = 18;

    localparam int READ_PHASES  = CACHE_BLOCK_DATA_LEN / SRAM_BUS_LEN;
    localparam int WRITE_PHASES = SRAM_DATA_LEN / SRAM_BUS_LEN;

    typedef enum logic [1:0] {
        SRAM_IDLE_STATE  = 2'd0,
        SRAM_READ_STATE  = 2'd1,
        SRAM_WRITE_STATE = 2'd2,
        SRAM_DONE_STATE  = 2'd3
    } sram_state_e;

    // Request addresses below the window wrap around and alias into the top of the chip.
    function automatic logic [ADDRESS_LEN-1:0] sram_offset(
        input logic [ADDRESS_LEN-1:0] addr,
        input logic [ADDRESS_LEN-1:0] base
    );
        return addr - base;
    endfunction

endpackage

// File: rtl/sram_access_timer.sv
// Paces one SRAM access: counts cycles within a halfword phase and the phase index,
// flagging the penultimate/last cycle of a phase and the final phase.
module sram_access_timer
    import sram_controller_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_enable,
    input  logic [1:0] i_last_phase_idx,
    output logic       o_last_cycle,
    output logic       o_pre_last_cycle,
    output logic       o_last_phase,
    output logic [1:0] o_phase
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    logic [CW-1:0] r_cycle;
    logic [1:0]    r_phase;

    assign o_last_cycle     = (r_cycle == CW'(ACCESS_CYCLES - 1));
    assign o_pre_last_cycle = (r_cycle == CW'(ACCESS_CYCLES - 2));
    assign o_last_phase     = (r_phase == i_last_phase_idx);
    assign o_phase          = r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle <= '0;
            r_phase <= '0;
        end else if (i_start) begin
            r_cycle <= '0;
            r_phase <= '0;
        end else if (i_enable) begin
            if (o_last_cycle) begin
                r_cycle <= '0;
                r_phase <= r_phase + 2'd1;
            end else begin
                r_cycle <= r_cycle + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Memory-side responder for the cache controller: word writes and 64-bit block reads
// against a 16-bit asynchronous SRAM, with a one-cycle ready pulse on completion.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sram_read_en,
    input  logic                            sram_write_en,
    input  logic [ADDRESS_LEN-1:0]          sram_address,
    input  logic [SRAM_DATA_LEN-1:0]        sram_write_data,
    output logic [CACHE_BLOCK_DATA_LEN-1:0] read_data,
    output logic                            ready,
    inout  wire  [SRAM_BUS_LEN-1:0]         SRAM_DQ,
    output logic [SRAM_ADDR_LEN-1:0]        SRAM_ADDR,
    output logic                            SRAM_WE_N,
    output logic                            SRAM_UB_N,
    output logic                            SRAM_LB_N,
    output logic                            SRAM_CE_N,
    output logic                            SRAM_OE_N
);

    sram_state_e                     r_state;
    logic [16:0]                     r_off;
    logic [SRAM_DATA_LEN-1:0]        r_wdata;
    logic [CACHE_BLOCK_DATA_LEN-1:0] r_read_data;
    logic                            r_ready;
    logic                            r_we_n;
    logic [SRAM_ADDR_LEN-1:0]        r_sram_addr;
    logic                            r_dq_oe;
    logic [SRAM_BUS_LEN-1:0]         r_dq_out;

    logic [ADDRESS_LEN-1:0] w_off_in;
    logic                   w_unused_off;
    logic                   w_accept;
    logic                   w_timer_en;
    logic [1:0]             w_last_phase_idx;
    logic                   w_last_cycle;
    logic                   w_pre_last_cycle;
    logic                   w_last_phase;
    logic [1:0]             w_phase;

    assign w_off_in     = sram_offset(sram_address, ADDRESS_LEN'(BASE_ADDR));
    assign w_unused_off = ^{w_off_in[ADDRESS_LEN-1:19], w_off_in[1:0]};

    assign w_accept         = (r_state == SRAM_IDLE_STATE) && (sram_write_en || sram_read_en);
    assign w_timer_en       = (r_state == SRAM_READ_STATE) || (r_state == SRAM_WRITE_STATE);
    assign w_last_phase_idx = (r_state == SRAM_WRITE_STATE) ? 2'(WRITE_PHASES - 1)
                                                            : 2'(READ_PHASES - 1);

    sram_access_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .i_start         (w_accept),
        .i_enable        (w_timer_en),
        .i_last_phase_idx(w_last_phase_idx),
        .o_last_cycle    (w_last_cycle),
        .o_pre_last_cycle(w_pre_last_cycle),
        .o_last_phase    (w_last_phase),
        .o_phase         (w_phase)
    );

    // Pin-facing signals are registered one step ahead so WE_N, address and data
    // change only on clock edges and never glitch toward the asynchronous chip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SRAM_IDLE_STATE;
            r_off       <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_ready     <= 1'b0;
            r_we_n      <= 1'b1;
            r_sram_addr <= '0;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                SRAM_IDLE_STATE: begin
                    if (sram_write_en) begin
                        r_state     <= SRAM_WRITE_STATE;
                        r_off       <= w_off_in[18:2];
                        r_wdata     <= sram_write_data;
                        r_sram_addr <= {w_off_in[18:2], 1'b0};
                        r_dq_out    <= sram_write_data[15:0];
                        r_dq_oe     <= 1'b1;
                        r_we_n      <= 1'b0;
                    end else if (sram_read_en) begin
                        r_state     <= SRAM_READ_STATE;
                        r_off       <= w_off_in[18:2];
                        r_sram_addr <= {w_off_in[18:3], 2'b00};
                        r_dq_oe     <= 1'b0;
                        r_we_n      <= 1'b1;
                    end
                end
                SRAM_READ_STATE: begin
                    if (w_last_cycle) begin
                        r_read_data[{w_phase, 4'b0000} +: SRAM_BUS_LEN] <= SRAM_DQ;
                        if (w_last_phase) begin
                            r_state <= SRAM_DONE_STATE;
                            r_ready <= 1'b1;
                        end else begin
                            r_sram_addr <= {r_off[16:1], w_phase + 2'd1};
                        end
                    end
                end
                // WE_N rises one cycle before the phase ends so the chip latches stable data.
                SRAM_WRITE_STATE: begin
                    if (w_last_cycle) begin
                        if (w_last_phase) begin
                            r_state <= SRAM_DONE_STATE;
                            r_ready <= 1'b1;
                            r_dq_oe <= 1'b0;
                            r_we_n  <= 1'b1;
                        end else begin
                            r_sram_addr <= {r_off, 1'b1};
                            r_dq_out    <= r_wdata[31:16];
                            r_we_n      <= 1'b0;
                        end
                    end else if (w_pre_last_cycle) begin
                        r_we_n <= 1'b1;
                    end
                end
                SRAM_DONE_STATE: begin
                    r_state <= SRAM_IDLE_STATE;
                end
                default: begin
                    r_state <= SRAM_IDLE_STATE;
                end
            endcase
        end
    end

    assign SRAM_DQ   = r_dq_oe ? r_dq_out : {SRAM_BUS_LEN{1'bz}};
    assign SRAM_ADDR = r_sram_addr;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign read_data = r_read_data;
    assign ready     = r_ready;

endmodule
